init_operand_sequencer: RTL and testbench

// Upstream operand source for the InitProcess arithmetic stage. Holds a DIM x DIM

---
 rtl/init_operand_sequencer.sv | 169 ++++++++++++++++
 tb/tb_init_operand_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/init_operand_sequencer.sv
// init_operand_sequencer
//
// Operand source for the InitProcess arithmetic stage. Holds a DIM x DIM table of
// NX-bit entries, preset at reset to the row-major index pattern (r*DIM + c). A run
// launched by START streams one (A, B) pair per accepted transfer in row-major order,
// with A = arr[r][c] and B = arr[c][r]. The table can be rewritten through the write
// port while idle. Writes attempted during a run leave the table unchanged and raise
// the sticky WR_ERR flag.
//
// Ports
//   CLK, RST_N            clock (rising edge), asynchronous active-low reset
//   START                 launch a run (sampled in IDLE only, ignored together with WR_EN)
//   WR_EN/ROW/COL/DATA    table write port
//   A, B, VALID, READY    operand stream with valid/ready handshake
//   BUSY                  high while running or signalling done
//   DONE                  one-cycle pulse after the last pair transfers
//   WR_ERR                sticky flag for writes attempted outside IDLE
module init_operand_sequencer #(
    parameter int unsigned NX  = 8,
    parameter int unsigned DIM = 4,
    localparam int unsigned IW = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          START,
    input  logic          WR_EN,
    input  logic [IW-1:0] WR_ROW,
    input  logic [IW-1:0] WR_COL,
    input  logic [NX-1:0] WR_DATA,
    output logic [NX-1:0] A,
    output logic [NX-1:0] B,
    output logic          VALID,
    input  logic          READY,
    output logic          BUSY,
    output logic          DONE,
    output logic          WR_ERR
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [IW-1:0] LastIdx = IW'(DIM - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] r_q, r_d;
    logic [IW-1:0] c_q, c_d;
    logic [NX-1:0] a_q, a_d;
    logic [NX-1:0] b_q, b_d;
    logic          valid_q, valid_d;
    logic          wr_err_q, wr_err_d;
    logic [NX-1:0] arr_q [DIM][DIM];
    logic [NX-1:0] arr_d [DIM][DIM];

    // Indices of the pair following (r_q, c_q) in row-major order.
    logic [IW-1:0] nr, nc;
    logic          last_pair;
    logic          wr_in_range;

    always_comb begin
        last_pair   = (r_q == LastIdx) && (c_q == LastIdx);
        nr          = r_q;
        nc          = c_q + 1'b1;
        if (c_q == LastIdx) begin
            nc = '0;
            nr = r_q + 1'b1;
        end
        // Only matters when DIM is not a power of two.
        wr_in_range = (32'(WR_ROW) < DIM) && (32'(WR_COL) < DIM);
    end

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        c_d      = c_q;
        a_d      = a_q;
        b_d      = b_q;
        valid_d  = valid_q;
        wr_err_d = wr_err_q;
        arr_d    = arr_q;

        unique case (state_q)
            StIdle: begin
                valid_d = 1'b0;
                if (WR_EN) begin
                    // A write always wins over START in the same cycle.
                    if (wr_in_range) begin
                        arr_d[WR_ROW][WR_COL] = WR_DATA;
                    end
                end else if (START) begin
                    state_d  = StRun;
                    r_d      = '0;
                    c_d      = '0;
                    a_d      = arr_q[0][0];
                    b_d      = arr_q[0][0];
                    valid_d  = 1'b1;
                    wr_err_d = 1'b0;
                end
            end

            StRun: begin
                if (WR_EN) begin
                    wr_err_d = 1'b1;
                end
                if (valid_q && READY) begin
                    if (last_pair) begin
                        valid_d = 1'b0;
                        state_d = StDone;
                    end else begin
                        // Reload from the next indices so pairs flow back-to-back.
                        r_d = nr;
                        c_d = nc;
                        a_d = arr_q[nr][nc];
                        b_d = arr_q[nc][nr];
                    end
                end
            end

            StDone: begin
                if (WR_EN) begin
                    wr_err_d = 1'b1;
                end
                valid_d = 1'b0;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= StIdle;
            r_q      <= '0;
            c_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            valid_q  <= 1'b0;
            wr_err_q <= 1'b0;
            for (int unsigned i = 0; i < DIM; i++) begin
                for (int unsigned j = 0; j < DIM; j++) begin
                    arr_q[i][j] <= NX'(i * DIM + j);
                end
            end
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            c_q      <= c_d;
            a_q      <= a_d;
            b_q      <= b_d;
            valid_q  <= valid_d;
            wr_err_q <= wr_err_d;
            arr_q    <= arr_d;
        end
    end

    assign A      = a_q;
    assign B      = b_q;
    assign VALID  = valid_q;
    assign BUSY   = (state_q != StIdle);
    assign DONE   = (state_q == StDone);
    assign WR_ERR = wr_err_q;

endmodule

// File: tb/tb_init_operand_sequencer.sv
module tb_init_operand_sequencer;

    localparam int NX  = 8;
    localparam int DIM = 4;

    logic          CLK;
    logic          RST_N;
    logic          START;
    logic          WR_EN;
    logic [1:0]    WR_ROW;
    logic [1:0]    WR_COL;
    logic [NX-1:0] WR_DATA;
    logic [NX-1:0] A;
    logic [NX-1:0] B;
    logic          VALID;
    logic          READY;
    logic          BUSY;
    logic          DONE;
    logic          WR_ERR;

    int checks = 0;
    int errors = 0;

    // Reference table: what the DUT table should hold.
    int mdl [DIM][DIM];

    init_operand_sequencer #(
        .NX (NX),
        .DIM(DIM)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .START  (START),
        .WR_EN  (WR_EN),
        .WR_ROW (WR_ROW),
        .WR_COL (WR_COL),
        .WR_DATA(WR_DATA),
        .A      (A),
        .B      (B),
        .VALID  (VALID),
        .READY  (READY),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .WR_ERR (WR_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                mdl[r][c] = (r * DIM + c) % 256;
    endtask

    // Idle-time table write; caller sits #1 after a rising edge.
    task automatic idle_write(input int r, input int c, input int d);
        WR_EN   = 1'b1;
        WR_ROW  = 2'(r);
        WR_COL  = 2'(c);
        WR_DATA = 8'(d);
        @(posedge CLK); #1;
        WR_EN = 1'b0;
        mdl[r][c] = d;
    endtask

    // One run. mode: 0 READY=1, 1 random READY, 2 three-cycle stall at pair 5.
    // wr_at/st_at/rst_at: pair index at which to poke WR_EN/START/RST_N (-1 = never).
    task automatic run(input int mode, input int wr_at, input int st_at,
                       input bit st_done, input int rst_at);
        int q_a[$];
        int q_b[$];
        int idx, stalls, vcyc, cyc;
        bit done_seen, hold, wr_done;
        logic [NX-1:0] pa, pb;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                q_a.push_back(mdl[r][c]);
                q_b.push_back(mdl[c][r]);
            end
        idx = 0; stalls = 0; vcyc = 0; cyc = 0;
        done_seen = 0; hold = 0; wr_done = 0;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        chk("start_clears_wr_err", WR_ERR, 0);
        while (!done_seen && cyc < 200) begin
            cyc++;
            if (DONE) begin
                done_seen = 1;
                chk("done_cycle", cyc, 17 + stalls);
                chk("done_valid_low", VALID, 0);
                chk("done_busy_high", BUSY, 1);
                if (st_done) START = 1'b1;
            end else begin
                chk("run_valid", VALID, 1);
                chk("run_busy", BUSY, 1);
                if (hold) begin
                    chk("hold_a", A, pa);
                    chk("hold_b", B, pb);
                end
                vcyc++;
                if (idx == rst_at) begin
                    #2 RST_N = 1'b0;
                    #1;
                    chk("rst_valid", VALID, 0);
                    chk("rst_busy", BUSY, 0);
                    chk("rst_a", A, 0);
                    chk("rst_b", B, 0);
                    chk("rst_done", DONE, 0);
                    READY = 1'b0;
                    return;
                end
                case (mode)
                    0:       READY = 1'b1;
                    1:       READY = ($urandom_range(0, 2) != 0);
                    default: READY = !(idx == 5 && stalls < 3);
                endcase
                if (idx == wr_at && !wr_done) begin
                    wr_done = 1;
                    WR_EN   = 1'b1;
                    WR_ROW  = 2'd0;
                    WR_COL  = 2'd0;
                    WR_DATA = 8'h55;
                end
                if (idx == st_at) START = 1'b1;
                if (READY) begin
                    chk($sformatf("pair%0d_a", idx), A, q_a[idx]);
                    chk($sformatf("pair%0d_b", idx), B, q_b[idx]);
                    idx++;
                    hold = 0;
                end else begin
                    stalls++;
                    hold = 1;
                    pa = A;
                    pb = B;
                end
            end
            @(posedge CLK); #1;
            WR_EN = 1'b0;
            START = 1'b0;
        end
        chk("done_seen", done_seen, 1);
        chk("pair_count", idx, DIM * DIM);
        chk("valid_cycles", vcyc, DIM * DIM + stalls);
        chk("after_busy_low", BUSY, 0);
        chk("after_valid_low", VALID, 0);
        chk("after_done_low", DONE, 0);
        READY = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0; START = 1'b0; WR_EN = 1'b0; READY = 1'b0;
        WR_ROW = '0; WR_COL = '0; WR_DATA = '0;
        model_reset();
        #12;
        chk("reset_a", A, 0);
        chk("reset_b", B, 0);
        chk("reset_valid", VALID, 0);
        chk("reset_busy", BUSY, 0);
        chk("reset_done", DONE, 0);
        chk("reset_wr_err", WR_ERR, 0);
        @(posedge CLK); #3 RST_N = 1'b1;
        @(posedge CLK); #1;

        // Plain run, full throughput.
        run(0, -1, -1, 0, -1);
        // Three-cycle backpressure on pair (1,1).
        run(2, -1, -1, 0, -1);
        // Idle write, then transpose shows it in both A and B.
        idle_write(1, 2, 8'hAA);
        run(0, -1, -1, 0, -1);
        // Write attempted mid-run: table untouched, sticky error.
        run(1, 2, -1, 0, -1);
        chk("wr_err_set", WR_ERR, 1);
        repeat (3) @(posedge CLK);
        #1 chk("wr_err_sticky", WR_ERR, 1);
        run(0, -1, -1, 0, -1);
        // START during run and during DONE ignored.
        run(1, -1, 4, 1, -1);
        // START with WR_EN in IDLE: write only.
        START = 1'b1;
        idle_write(3, 0, 8'h3C);
        START = 1'b0;
        chk("st_wr_valid", VALID, 0);
        chk("st_wr_busy", BUSY, 0);
        @(posedge CLK); #1;
        chk("st_wr_still_idle", BUSY, 0);
        run(1, -1, -1, 0, -1);
        // Async reset mid-run restores table and state.
        run(1, -1, -1, 0, 6);
        model_reset();
        #2 RST_N = 1'b1;
        @(posedge CLK); #1;
        chk("post_rst_wr_err", WR_ERR, 0);
        chk("post_rst_busy", BUSY, 0);
        run(0, -1, -1, 0, -1);
        run(1, -1, -1, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
